// File: rtl/regfile_pkg.sv
// Shared register-file constants.
// Used by the register file and its write arbiter.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int CNT_W    = 16;
  localparam int GID_W    = 2;

  localparam logic [CNT_W-1:0] RST_CNT = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GID_W-1:0] RST_GID = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant scan with a rotating
// priority pointer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [1:0]   grant_idx
);

  logic [1:0] ptr;

  // Pick the requester closest to ptr going upward.
  always_comb begin : scan
    int best;
    int sel;
    int d;
    best = N;
    sel  = 0;
    d    = 0;
    for (int i = 0; i < N; i++) begin
      d = (i + N - int'(ptr)) % N;
      if (req[i] && d < best) begin
        best = d;
        sel  = i;
      end
    end
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = (best < N) && (i == sel);
    end
    grant_idx = 2'(sel);
  end

  // Move priority past the last winner.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      if (grant_idx == 2'(N - 1))
        ptr <= '0;
      else
        ptr <= grant_idx + 2'd1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port
// and registers the winner into one stage.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = regfile_pkg::DATA_W,
  parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wr_stall,
  output logic                      regWrite,
  output logic [ADDR_W-1:0]         writeRegNo,
  output logic [DATA_W-1:0]         writeData,
  output logic [1:0]                grant_id,
  output logic [(1<<ADDR_W)-1:0]    pend_mask,
  output logic [15:0]               wr_count
);

  import regfile_pkg::*;

  logic [NUM_REQ-1:0] req_live;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         gidx;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;

  // Reset and stall both hide every request.
  assign req_live =
    (reset && !wr_stall) ? req_valid : '0;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (req_live),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  // Steer the winning request's payload.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // One-deep write stage plus write counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      regWrite   <= 1'b0;
      writeRegNo <= '0;
      writeData  <= '0;
      grant_id   <= RST_GID;
      wr_count   <= RST_CNT;
    end else begin
      regWrite <= xfer;
      if (xfer) begin
        writeRegNo <= sel_reg;
        writeData  <= sel_data;
        grant_id   <= gidx;
        if (wr_count != CNT_MAX)
          wr_count <= wr_count + 16'd1;
      end
    end
  end

  // Register being written this cycle.
  always_comb begin
    pend_mask = '0;
    if (regWrite)
      pend_mask[writeRegNo] = 1'b1;
  end

endmodule
